// File: rtl/div_sequencer.sv
// div_sequencer
// Iterative radix-2 restoring divider controller for DIV/DIVU on the EX-stage
// HI/LO path. It stalls the pipeline while working and presents the quotient
// (LO) and remainder (HI) behind a registered ready flag. A flush aborts any
// divide in progress without disturbing the last delivered result.

module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             stall_req_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // Working registers: r_dvdQ starts as |dividend| and is shifted left one bit
  // per step, with each new quotient bit entering at the bottom. After WIDTH
  // steps it holds the unsigned quotient.
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dvdQ;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_negQ;
  logic             r_negR;
  logic             r_ready;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remOut;

  logic             w_dvdNeg;
  logic             w_dvsNeg;
  logic [WIDTH-1:0] w_dvdAbs;
  logic [WIDTH-1:0] w_dvsAbs;
  logic             w_accept;
  logic [WIDTH:0]   w_partial;
  logic             w_fits;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_remStep;
  logic [WIDTH-1:0] w_quotStep;
  logic             w_lastStep;
  logic [WIDTH-1:0] w_quotFinal;
  logic [WIDTH-1:0] w_remFinal;

  // Operand magnitudes and sign flags. Negating the most negative value wraps
  // to itself, which is exactly the unsigned magnitude we need.
  assign w_dvdNeg = signed_i & dividend_i[WIDTH-1];
  assign w_dvsNeg = signed_i & divisor_i[WIDTH-1];
  assign w_dvdAbs = w_dvdNeg ? (-dividend_i) : dividend_i;
  assign w_dvsAbs = w_dvsNeg ? (-divisor_i) : divisor_i;
  assign w_accept = (r_state == IDLE) && start_i && !annul_i;

  // One restoring step. The partial remainder keeps an extra top bit because
  // an unsigned divisor may use every bit, so 2*rem+1 can exceed WIDTH bits.
  // When the divisor fits, the difference is below the divisor and thus
  // always representable in WIDTH bits.
  assign w_partial  = {r_rem, r_dvdQ[WIDTH-1]};
  assign w_fits     = (w_partial >= {1'b0, r_dvs});
  assign w_diff     = w_partial[WIDTH-1:0] - r_dvs;
  assign w_remStep  = w_fits ? w_diff : w_partial[WIDTH-1:0];
  assign w_quotStep = {r_dvdQ[WIDTH-2:0], w_fits};
  assign w_lastStep = (r_state == RUN) && (r_count == CW'(WIDTH - 1));

  // Sign fix-up applied to the final step's results before loading outputs.
  assign w_quotFinal = r_negQ ? (-w_quotStep) : w_quotStep;
  assign w_remFinal  = r_negR ? (-w_remStep) : w_remStep;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state selection and the combinational pipeline stall request.
  always_comb begin
    w_stateNext = r_state;
    stall_req_o = 1'b0;
    if (annul_i) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          stall_req_o = start_i;
          if (start_i) begin
            w_stateNext = (divisor_i == '0) ? BYZERO : RUN;
          end
        end
        BYZERO: begin
          stall_req_o = 1'b1;
          w_stateNext = DONE;
        end
        RUN: begin
          stall_req_o = 1'b1;
          if (r_count == CW'(WIDTH - 1)) begin
            w_stateNext = DONE;
          end
        end
        DONE: begin
          if (!start_i) begin
            w_stateNext = IDLE;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // Iteration datapath: latch operands on acceptance, then step once per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_dvdQ  <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
    end else if (w_accept && (divisor_i != '0)) begin
      r_count <= '0;
      r_dvdQ  <= w_dvdAbs;
      r_rem   <= '0;
      r_dvs   <= w_dvsAbs;
      r_negQ  <= w_dvdNeg ^ w_dvsNeg;
      r_negR  <= w_dvdNeg;
    end else if ((r_state == RUN) && !annul_i) begin
      r_count <= r_count + 1'b1;
      r_dvdQ  <= w_quotStep;
      r_rem   <= w_remStep;
    end
  end

  // Result registers and ready flag; a flush drops ready but keeps the old result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_quot   <= '0;
      r_remOut <= '0;
    end else if (annul_i) begin
      r_ready <= 1'b0;
    end else if (r_state == BYZERO) begin
      r_ready  <= 1'b1;
      r_quot   <= '0;
      r_remOut <= '0;
    end else if (w_lastStep) begin
      r_ready  <= 1'b1;
      r_quot   <= w_quotFinal;
      r_remOut <= w_remFinal;
    end else if ((r_state == DONE) && !start_i) begin
      r_ready <= 1'b0;
    end
  end

  assign ready_o     = r_ready;
  assign quotient_o  = r_quot;
  assign remainder_o = r_remOut;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
// Self-checking bench for div_sequencer: directed corner cases followed by
// randomized DIV/DIVU requests compared against an arithmetic reference.

module tb_div_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic             annul_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             stall_req_o;
  logic             ready_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;

  int testsRun  = 0;
  int failCount = 0;

  div_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .stall_req_o (stall_req_o),
    .ready_o     (ready_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever gets stuck.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference divide from the sign rules using wide integer arithmetic.
  function automatic void refDiv(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, ma, mb, mq, mr;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
      return;
    end
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    mq = ma / mb;
    mr = ma % mb;
    if ((sa < 0) != (sb < 0)) mq = -mq;
    if (sa < 0) mr = -mr;
    q = 32'(mq);
    r = 32'(mr);
  endfunction

  // Issue one divide, track stall and ready timing, check results, hold, release.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eq, er;
    int readyCyc;
    int stallBad;
    int expLat;
    refDiv(s, a, b, eq, er);
    expLat = (b == 32'd0) ? 2 : WIDTH + 1;
    @(posedge clk); #1;
    signed_i = s; dividend_i = a; divisor_i = b; start_i = 1'b1;
    #1;
    checkOutput({tag, ":stall0"}, 32'(stall_req_o), 32'd1);
    readyCyc = -1;
    stallBad = 0;
    for (int cyc = 1; cyc <= WIDTH + 4; cyc++) begin
      @(posedge clk); #1;
      dividend_i = $urandom;
      divisor_i  = $urandom;
      signed_i   = 1'($urandom_range(0, 1));
      #1;
      if (ready_o) begin
        readyCyc = cyc;
        break;
      end
      if (!stall_req_o) stallBad++;
    end
    checkOutput({tag, ":latency"}, 32'(readyCyc), 32'(expLat));
    checkOutput({tag, ":stallBusy"}, 32'(stallBad), 32'd0);
    checkOutput({tag, ":stallDone"}, 32'(stall_req_o), 32'd0);
    checkOutput({tag, ":quot"}, quotient_o, eq);
    checkOutput({tag, ":rem"}, remainder_o, er);
    @(posedge clk); #1;
    #1;
    checkOutput({tag, ":holdReady"}, 32'(ready_o), 32'd1);
    checkOutput({tag, ":holdQuot"}, quotient_o, eq);
    start_i = 1'b0;
    @(posedge clk); #1;
    #1;
    checkOutput({tag, ":dropReady"}, 32'(ready_o), 32'd0);
    checkOutput({tag, ":keepRem"}, remainder_o, er);
  endtask

  // Start a divide, flush it at cycle 10, and confirm nothing is delivered.
  task automatic annulStimulus();
    logic [31:0] oldQ, oldR;
    int rose;
    oldQ = quotient_o;
    oldR = remainder_o;
    @(posedge clk); #1;
    signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
    end
    annul_i = 1'b1;
    #1;
    checkOutput("annul:stallC10", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("annul:stallC11", 32'(stall_req_o), 32'd0);
    rose = 0;
    for (int cyc = 0; cyc < WIDTH + 10; cyc++) begin
      @(posedge clk); #1;
      if (ready_o || stall_req_o) rose++;
    end
    checkOutput("annul:noResult", 32'(rose), 32'd0);
    checkOutput("annul:keepQuot", quotient_o, oldQ);
    checkOutput("annul:keepRem", remainder_o, oldR);
  endtask

  // Assert reset mid-RUN between clock edges and check the immediate effect.
  task automatic resetStimulus();
    @(posedge clk); #1;
    signed_i = 1'b0; dividend_i = 32'd12345; divisor_i = 32'd11; start_i = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk); #1;
    end
    #2;
    start_i = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rstMid:ready", 32'(ready_o), 32'd0);
    checkOutput("rstMid:quot", quotient_o, 32'd0);
    checkOutput("rstMid:rem", remainder_o, 32'd0);
    checkOutput("rstMid:stallIdle", 32'(stall_req_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic s;
    logic [31:0] a, b;
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_i = 1'b0;
    dividend_i = '0;
    divisor_i = '0;
    #12;
    checkOutput("reset:ready", 32'(ready_o), 32'd0);
    checkOutput("reset:quot", quotient_o, 32'd0);
    checkOutput("reset:rem", remainder_o, 32'd0);
    checkOutput("reset:stall", 32'(stall_req_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7, "divu100_7");
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, "div-7_2");
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, "div7_-2");
    applyStimulus(1'b0, 32'd55, 32'd0, "divByZero");
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "divMinNeg1");
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divuMinNeg1");
    annulStimulus();
    applyStimulus(1'b0, 32'd1000, 32'd3, "afterAnnul");
    resetStimulus();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, "afterRst");

    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      applyStimulus(s, a, b, "random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
